// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle between the issue logic and multicycle_alu.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             div0;
  logic             busy;
  logic             done;

  modport master (
    output start, operation, a, b,
    input  result, result_hi, zero, ovf, div0, busy, done
  );

  modport slave (
    input  start, operation, a, b,
    output result, result_hi, zero, ovf, div0, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative signed mul/div.
// Optional feature: define ALU_OVF_EN to report signed overflow on add/sub.
module multicycle_alu #(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  multicycle_alu_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_AND = 4'b1101;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             is_div_q, is_div_d;
  logic             by_zero_q, by_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Single-cycle result
  logic [WIDTH-1:0] sum_ab, diff_ab, alu_res, abs_a, abs_b;
  logic [W2-1:0]    dbl_a, ror_full, rol_full;
  logic [CW-1:0]    sh;
  logic             alu_ovf;

  assign sum_ab   = bus.a + bus.b;
  assign diff_ab  = bus.a - bus.b;
  assign sh       = bus.b[CW-1:0];
  assign dbl_a    = {bus.a, bus.a};
  assign ror_full = dbl_a >> sh;
  assign rol_full = dbl_a << sh;
  assign abs_a    = bus.a[WIDTH-1] ? WIDTH'(-bus.a) : bus.a;
  assign abs_b    = bus.b[WIDTH-1] ? WIDTH'(-bus.b) : bus.b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        alu_res = sum_ab;
`ifdef ALU_OVF_EN
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ab[WIDTH-1] != bus.a[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        alu_res = diff_ab;
`ifdef ALU_OVF_EN
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ab[WIDTH-1] != bus.a[WIDTH-1]);
`endif
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SHR:  alu_res = bus.a >> sh;
      OP_SHL:  alu_res = bus.a << sh;
      OP_ROR:  alu_res = ror_full[WIDTH-1:0];
      OP_ROL:  alu_res = rol_full[W2-1:WIDTH];
      default: alu_res = '0;
    endcase
  end

  // One shift-add / restoring step on the shared accumulator {hi, lo}
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [W2-1:0]    mul_next, div_next;
  logic             div_ok;

  assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_b_q : WIDTH'(0))};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ok};

  // Sign fix applied in FIN
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  assign prod_s = res_neg_q ? W2'(-acc_q) : acc_q;
  assign quo_s  = res_neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_s  = rem_neg_q ? WIDTH'(-acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mag_b_q     <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      is_div_q    <= 1'b0;
      by_zero_q   <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mag_b_q     <= mag_b_d;
      res_neg_q   <= res_neg_d;
      rem_neg_q   <= rem_neg_d;
      is_div_q    <= is_div_d;
      by_zero_q   <= by_zero_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL) state_d = MUL;
          else if (bus.operation == OP_DIV) state_d = (bus.b == '0) ? FIN : DIV;
        end
      end
      MUL:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      DIV:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mag_b_d     = mag_b_q;
    res_neg_d   = res_neg_q;
    rem_neg_d   = rem_neg_q;
    is_div_d    = is_div_q;
    by_zero_d   = by_zero_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL || bus.operation == OP_DIV) begin
            acc_d     = {WIDTH'(0), abs_a};
            mag_b_d   = abs_b;
            res_neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rem_neg_d = bus.a[WIDTH-1];
            is_div_d  = (bus.operation == OP_DIV);
            by_zero_d = 1'b0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            // Divide-by-zero keeps the raw dividend for result_hi
            if (bus.operation == OP_DIV && bus.b == '0) begin
              acc_d     = {WIDTH'(0), bus.a};
              by_zero_d = 1'b1;
            end
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            div0_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
      end
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        ovf_d  = 1'b0;
        if (by_zero_q) begin
          result_d    = '1;
          result_hi_d = acc_q[WIDTH-1:0];
          zero_d      = 1'b0;
          div0_d      = 1'b1;
        end else if (is_div_q) begin
          result_d    = quo_s;
          result_hi_d = rem_s;
          zero_d      = (quo_s == '0);
          div0_d      = 1'b0;
        end else begin
          result_d    = prod_s[WIDTH-1:0];
          result_hi_d = prod_s[W2-1:WIDTH];
          zero_d      = (prod_s == '0);
          div0_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus random ops against an arithmetic model.
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  multicycle_alu_if #(.WIDTH(16)) bus ();
  multicycle_alu #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the op definitions, using integer arithmetic
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [15:0] rh, output logic z,
                       output logic o, output logic d0, output int lat);
    int    sa, sb, s, sh, q, m;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    r = 16'h0; rh = 16'h0; o = 1'b0; d0 = 1'b0; lat = 1;
    case (op)
      4'b1111: begin
        s = sa + sb; r = 16'(s);
`ifdef ALU_OVF_EN
        o = (s < -32768) || (s > 32767);
`endif
      end
      4'b1110: begin
        s = sa - sb; r = 16'(s);
`ifdef ALU_OVF_EN
        o = (s < -32768) || (s > 32767);
`endif
      end
      4'b1101: r = a & b;
      4'b1100: r = a | b;
      4'b1011: r = 16'(int'(a) >> sh);
      4'b1010: r = 16'(int'(a) << sh);
      4'b1001: r = 16'((int'(a) >> sh) | (int'(a) << (16 - sh)));
      4'b1000: r = 16'((int'(a) << sh) | (int'(a) >> (16 - sh)));
      4'b0001: begin
        p = longint'(sa) * longint'(sb);
        r = 16'(p); rh = 16'(p >>> 16); lat = 18;
      end
      4'b0010: begin
        if (b == 16'h0) begin
          r = 16'hFFFF; rh = a; d0 = 1'b1; lat = 2;
        end else begin
          q = sa / sb; m = sa % sb;
          r = 16'(q); rh = 16'(m); lat = 18;
        end
      end
      default: r = 16'h0;
    endcase
    z = (op == 4'b0001) ? ({rh, r} == 32'h0) : (r == 16'h0);
  endtask

  // Issue one op (in the current cycle), wait for done, check timing and results
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, rh;
    logic z, o, d0;
    int lat, cycles, busy_cnt;
    model(op, a, b, r, rh, z, o, d0, lat);
    bus.operation = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 1; busy_cnt = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, " latency"}, 32'(cycles), 32'(lat));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    chk({tag, " result"}, 32'(bus.result), 32'(r));
    chk({tag, " result_hi"}, 32'(bus.result_hi), 32'(rh));
    chk({tag, " zero"}, 32'(bus.zero), 32'(z));
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(o));
    chk({tag, " div0"}, 32'(bus.div0), 32'(d0));
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    logic [3:0] ops [14];
    logic [3:0] op;
    logic [15:0] ra, rb;
    int cycles, dones;
    ops = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h1, 4'h2, 4'h6, 4'h0, 4'h3, 4'h7};

    rst = 1'b1; bus.start = 1'b0; bus.operation = 4'h0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", 32'(bus.result), 32'h0);
    chk("reset result_hi", 32'(bus.result_hi), 32'h0);
    chk("reset flags", {27'h0, bus.zero, bus.ovf, bus.div0, bus.busy, bus.done}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf", 4'hF, 16'h7FFF, 16'h0001);
    chk("add_ovf exact", 32'(bus.result), 32'h8000);
    run_op("mul_neg", 4'h1, 16'hFFFD, 16'h0004);
    chk("mul_neg exact", {bus.result_hi, bus.result}, 32'hFFFF_FFF4);
    run_op("div_neg", 4'h2, 16'hFFF9, 16'h0002);
    chk("div_neg exact", {bus.result_hi, bus.result}, 32'hFFFF_FFFD);
    run_op("div_zero", 4'h2, 16'h1234, 16'h0000);
    run_op("rol", 4'h8, 16'h8001, 16'h0001);
    chk("rol exact", 32'(bus.result), 32'h0003);
    run_op("ror", 4'h9, 16'h8001, 16'h0001);
    chk("ror exact", 32'(bus.result), 32'hC000);
    run_op("shr15", 4'hB, 16'h8000, 16'h000F);
    chk("shr15 exact", 32'(bus.result), 32'h0001);
    run_op("shl0", 4'hA, 16'hBEEF, 16'h0000);
    run_op("ror0", 4'h9, 16'hBEEF, 16'h0010);
    run_op("nop6", 4'h6, 16'hFFFF, 16'hFFFF);
    run_op("sub_ovf", 4'hE, 16'h8000, 16'h0001);
    run_op("div_minneg", 4'h2, 16'h8000, 16'hFFFF);
    chk("div_minneg exact", {bus.result_hi, bus.result}, 32'h0000_8000);
    run_op("mul_minneg", 4'h1, 16'h8000, 16'h8000);
    run_op("mul_zero", 4'h1, 16'h0000, 16'h1234);
    run_op("div_rem_pos", 4'h2, 16'h0007, 16'hFFFE);
    run_op("add_after_mul", 4'hF, 16'h0001, 16'h0002);

    // start while busy is ignored and not queued
    bus.operation = 4'h1; bus.a = 16'hFFFD; bus.b = 16'h0004; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 1; dones = 0;
    while (!bus.done && cycles < 40) begin
      if (cycles == 3) begin
        bus.operation = 4'hF; bus.a = 16'h0005; bus.b = 16'h0006; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    chk("ignored_start latency", 32'(cycles), 32'd18);
    chk("ignored_start result", {bus.result_hi, bus.result}, 32'hFFFF_FFF4);
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("ignored_start no_extra_done", 32'(dones), 32'h0);

    // reset in the middle of a divide aborts it
    bus.operation = 4'h2; bus.a = 16'h1234; bus.b = 16'h0007; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'h0);
    chk("abort done", 32'(bus.done), 32'h0);
    chk("abort outputs", {bus.result_hi, bus.result}, 32'h0);
    chk("abort flags", {29'h0, bus.zero, bus.ovf, bus.div0}, 32'h0);
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort no_done", 32'(dones), 32'h0);

    // random ops, biased toward corner operands
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 13)];
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: ra = 16'h7FFF;
        3: rb = 16'($urandom_range(0, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0h", i, op), op, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
